// File: rtl/wma_filter_mc.sv
// Multi-channel weighted moving average with a valid/ready handshake on both sides.
// Each accepted sample updates its channel's running average and produces one result one clock later.
module wma_filter_mc #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned W_IN   = 3,
  parameter int unsigned W_OUT  = 1,
  parameter int unsigned W_HIST = 1,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] t1,
  input  logic [DATA_W-1:0] t2,
  input  logic [NUM_CH-1:0] ch_clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_wma,
  output logic              out_inband
);

  localparam int unsigned NUM_W = DATA_W + 5;
  localparam int unsigned DEN_W = 5;

  logic [NUM_CH-1:0][DATA_W-1:0] wma;
  logic [NUM_CH-1:0]             primed;

  logic              accept;
  logic              ch_ok;
  logic              hist_ok;
  logic              in_band;
  logic [DEN_W-1:0]  w;
  logic [DEN_W-1:0]  denom;
  logic [NUM_W-1:0]  num;
  logic [DATA_W-1:0] cur_wma;
  logic [DATA_W-1:0] new_wma;

  // Single output register: a new sample may enter whenever the held result leaves.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Weight selection and average update for the offered sample.
  always_comb begin
    ch_ok   = 32'(in_ch) < NUM_CH;
    cur_wma = '0;
    hist_ok = 1'b0;
    if (ch_ok) begin
      cur_wma = wma[in_ch];
      // A clear landing on the accepted channel makes this sample the first one.
      hist_ok = primed[in_ch] && !ch_clear[in_ch];
    end
    in_band = (t1 <= in_x) && (in_x < t2);
    w       = in_band ? DEN_W'(W_IN) : DEN_W'(W_OUT);
    denom   = w + DEN_W'(W_HIST);
    num     = NUM_W'(w) * NUM_W'(in_x) + NUM_W'(W_HIST) * NUM_W'(cur_wma);
    new_wma = hist_ok ? DATA_W'(num / NUM_W'(denom)) : in_x;
  end

  // Per-channel history; written on the accept edge so back-to-back samples see it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wma    <= '0;
      primed <= '0;
    end else begin
      primed <= primed & ~ch_clear;
      if (accept && ch_ok) begin
        wma[in_ch]    <= new_wma;
        primed[in_ch] <= 1'b1;
      end
    end
  end

  // Result register; held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_wma    <= '0;
      out_inband <= 1'b0;
    end else if (accept && ch_ok) begin
      out_valid  <= 1'b1;
      out_ch     <= in_ch;
      out_wma    <= new_wma;
      out_inband <= in_band;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
